// File: rtl/hazard_sched_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_sched_ctrl_pkg
// Shared definitions for the decode-side hazard scheduler: register file
// geometry, scheduler state encodings and the default pending-write counter
// width.
// ----------------------------------------------------------------------------
package hazard_sched_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_DEPTH = 32;
  localparam int PEND_W_DEF     = 2;

  typedef enum logic [1:0] {
    HS_RUN   = 2'd0,
    HS_FLUSH = 2'd1,
    HS_MWAIT = 2'd2
  } hs_state_e;

endpackage

// File: rtl/hazard_sched_ctrl_sb_counter_bank.sv
// ----------------------------------------------------------------------------
// hazard_sched_ctrl_sb_counter_bank
// One pending-write counter per architectural register. An issued write bumps
// its destination counter, a WB release drops it. Simultaneous bump and drop
// of the same register cancel out. Releasing a register whose counter is
// already zero leaves it at zero and raises the sticky error flag.
//
// Ports:
//   clk, rst_n   core clock, asynchronous active-low reset
//   inc_en/addr  increment request (caller excludes x0)
//   dec_en/addr  decrement request (caller excludes x0)
//   cnt          all counter values, for the hazard compare
//   busy         bit i set while counter i is non-zero
//   err          sticky release-underflow flag
// ----------------------------------------------------------------------------
module hazard_sched_ctrl_sb_counter_bank
  import hazard_sched_ctrl_pkg::*;
#(
  parameter int REG_NUM = REG_DATA_DEPTH,
  parameter int PEND_W  = PEND_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 inc_en,
  input  logic [REG_ADDR_WIDTH-1:0]            inc_addr,
  input  logic                                 dec_en,
  input  logic [REG_ADDR_WIDTH-1:0]            dec_addr,
  output logic [REG_NUM-1:0][PEND_W-1:0]       cnt,
  output logic [REG_NUM-1:0]                   busy,
  output logic                                 err
);

  logic [REG_NUM-1:0][PEND_W-1:0] cnt_q;
  logic                           err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (inc_en && (inc_addr == REG_ADDR_WIDTH'(i)) &&
            !(dec_en && (dec_addr == REG_ADDR_WIDTH'(i)))) begin
          // Overflow cannot happen: a full counter blocks issue upstream.
          cnt_q[i] <= cnt_q[i] + PEND_W'(1);
        end else if (dec_en && (dec_addr == REG_ADDR_WIDTH'(i)) &&
                     !(inc_en && (inc_addr == REG_ADDR_WIDTH'(i)))) begin
          if (cnt_q[i] == '0) begin
            err_q <= 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] - PEND_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  assign cnt = cnt_q;
  assign err = err_q;

endmodule

// File: rtl/hazard_sched_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_sched_ctrl
// Decode-side hazard scheduler for the in-order core. Tracks every
// outstanding register write in a per-register scoreboard and decides each
// cycle whether the ID instruction issues into EX, stalls the front end,
// flushes IF/ID after a taken redirect or freezes while memory is busy.
// Priority: mem_busy > ex_redirect > hazard.
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   id_valid                   ID holds a valid instruction
//   id_rs1_used/addr           rs1 read request
//   id_rs2_used/addr           rs2 read request
//   id_reg_wen/id_rd_addr      instruction writes rd
//   ex_redirect                taken branch/jump resolved in EX
//   mem_busy                   LSU outstanding, whole pipe freezes
//   wb_reg_wen/wb_reg_waddr    WB register file write (releases a pending write)
//   issue                      ID instruction accepted into EX
//   stall_if, stall_id         hold PC/IF and IF/ID
//   bubble_ex                  load NOP into ID/EX
//   flush_if_id                invalidate IF/ID
//   sb_busy                    per-register pending-write flag
//   sb_err                     sticky release-underflow flag
// ----------------------------------------------------------------------------
module hazard_sched_ctrl
  import hazard_sched_ctrl_pkg::*;
#(
  parameter int REG_NUM      = REG_DATA_DEPTH,
  parameter int PEND_W       = PEND_W_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic                      id_rs1_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                      ex_redirect,
  input  logic                      mem_busy,
  input  logic                      wb_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wb_reg_waddr,
  output logic                      issue,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic                      flush_if_id,
  output logic [REG_NUM-1:0]        sb_busy,
  output logic                      sb_err
);

  localparam int              FC_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

  hs_state_e                      state_q;
  logic [FC_W-1:0]                flush_cnt_q;
  logic [REG_NUM-1:0][PEND_W-1:0] cnt;
  logic [REG_NUM-1:0]             busy;
  logic                           err;

  logic raw1, raw2, waw_full, hazard;
  logic issue_c, stall_c, bubble_c, flush_c;
  logic sb_inc, sb_dec;

  // No WB bypass: a release only becomes visible after the edge that writes
  // the register file, so the compare uses the registered counters alone.
  assign raw1     = id_rs1_used && (id_rs1_addr != '0) && (cnt[id_rs1_addr] != '0);
  assign raw2     = id_rs2_used && (id_rs2_addr != '0) && (cnt[id_rs2_addr] != '0);
  assign waw_full = id_reg_wen  && (id_rd_addr  != '0) && (cnt[id_rd_addr] == '1);
  assign hazard   = raw1 || raw2 || waw_full;

  // MWAIT with mem_busy low behaves exactly like RUN, so only FLUSH is
  // distinguished here.
  always_comb begin
    issue_c  = 1'b0;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    if (mem_busy) begin
      stall_c = 1'b1;
    end else if (ex_redirect || (state_q == HS_FLUSH)) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
    end else if (!id_valid) begin
      bubble_c = 1'b1;
    end else if (hazard) begin
      stall_c  = 1'b1;
      bubble_c = 1'b1;
    end else begin
      issue_c = 1'b1;
    end
  end

  // Outputs are forced low combinationally while reset is held.
  assign issue       = rst_n && issue_c;
  assign stall_if    = rst_n && stall_c;
  assign stall_id    = rst_n && stall_c;
  assign bubble_ex   = rst_n && bubble_c;
  assign flush_if_id = rst_n && flush_c;
  assign sb_busy     = busy;
  assign sb_err      = err;

  // A redirect seen during mem_busy is left pending; EX holds it until the
  // freeze lifts, so it is taken in the first unfrozen cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HS_RUN;
      flush_cnt_q <= '0;
    end else if (mem_busy) begin
      state_q <= HS_MWAIT;
    end else if (ex_redirect) begin
      flush_cnt_q <= FLUSH_LOAD;
      state_q     <= (FLUSH_CYCLES > 1) ? HS_FLUSH : HS_RUN;
    end else if (state_q == HS_FLUSH) begin
      if (flush_cnt_q <= FC_W'(1)) begin
        flush_cnt_q <= '0;
        state_q     <= HS_RUN;
      end else begin
        flush_cnt_q <= flush_cnt_q - FC_W'(1);
      end
    end else begin
      state_q <= HS_RUN;
    end
  end

  assign sb_inc = issue_c && id_reg_wen && (id_rd_addr != '0);
  assign sb_dec = wb_reg_wen && (wb_reg_waddr != '0);

  hazard_sched_ctrl_sb_counter_bank #(
    .REG_NUM (REG_NUM),
    .PEND_W  (PEND_W)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_en   (sb_inc),
    .inc_addr (id_rd_addr),
    .dec_en   (sb_dec),
    .dec_addr (wb_reg_waddr),
    .cnt      (cnt),
    .busy     (busy),
    .err      (err)
  );

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
module tb_hazard_sched_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int PEND_MAX     = 3;

  typedef struct packed {
    logic       v;
    logic       r1u;
    logic [4:0] r1;
    logic       r2u;
    logic [4:0] r2;
    logic       w;
    logic [4:0] rd;
    logic       redir;
    logic       mbusy;
    logic       wbw;
    logic [4:0] wba;
  } stim_t;

  typedef struct packed {
    logic        issue;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_rs1_used, id_rs2_used, id_reg_wen;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr, wb_reg_waddr;
  logic ex_redirect, mem_busy, wb_reg_wen;
  logic issue, stall_if, stall_id, bubble_ex, flush_if_id, sb_err;
  logic [31:0] sb_busy;

  int n_chk = 0;
  int n_fail = 0;

  exp_t exp_q[$];

  int m_cnt[32];
  int m_state;
  int m_fc;
  bit m_err;

  logic        o_issue, o_stall, o_bubble, o_flush, o_err;
  logic [31:0] o_busy;

  hazard_sched_ctrl #(
    .REG_NUM      (32),
    .PEND_W       (2),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1_used  (id_rs1_used),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_used  (id_rs2_used),
    .id_rs2_addr  (id_rs2_addr),
    .id_reg_wen   (id_reg_wen),
    .id_rd_addr   (id_rd_addr),
    .ex_redirect  (ex_redirect),
    .mem_busy     (mem_busy),
    .wb_reg_wen   (wb_reg_wen),
    .wb_reg_waddr (wb_reg_waddr),
    .issue        (issue),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .bubble_ex    (bubble_ex),
    .flush_if_id  (flush_if_id),
    .sb_busy      (sb_busy),
    .sb_err       (sb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic stim_t ins(input int v, input int r1u, input int r1, input int r2u,
                                input int r2, input int w, input int rd);
    stim_t s;
    s       = '0;
    s.v     = v[0];
    s.r1u   = r1u[0];
    s.r1    = 5'(r1);
    s.r2u   = r2u[0];
    s.r2    = 5'(r2);
    s.w     = w[0];
    s.rd    = 5'(rd);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    id_valid     = s.v;
    id_rs1_used  = s.r1u;
    id_rs1_addr  = s.r1;
    id_rs2_used  = s.r2u;
    id_rs2_addr  = s.r2;
    id_reg_wen   = s.w;
    id_rd_addr   = s.rd;
    ex_redirect  = s.redir;
    mem_busy     = s.mbusy;
    wb_reg_wen   = s.wbw;
    wb_reg_waddr = s.wba;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_state = 0;
    m_fc    = 0;
    m_err   = 1'b0;
  endtask

  function automatic exp_t model_out(input stim_t s);
    exp_t e;
    bit   hz;
    e = '0;
    for (int i = 0; i < 32; i++) e.busy[i] = (m_cnt[i] != 0);
    e.err = m_err;
    hz = (s.r1u && s.r1 != 0 && m_cnt[s.r1] != 0) ||
         (s.r2u && s.r2 != 0 && m_cnt[s.r2] != 0) ||
         (s.w && s.rd != 0 && m_cnt[s.rd] == PEND_MAX);
    if (s.mbusy) e.stall = 1'b1;
    else if (s.redir || m_state == 1) begin e.flush = 1'b1; e.bubble = 1'b1; end
    else if (!s.v) e.bubble = 1'b1;
    else if (hz) begin e.stall = 1'b1; e.bubble = 1'b1; end
    else e.issue = 1'b1;
    return e;
  endfunction

  task automatic model_step(input stim_t s, input logic iss);
    for (int i = 1; i < 32; i++) begin
      bit inc, dec;
      inc = iss && s.w && (s.rd == 5'(i));
      dec = s.wbw && (s.wba == 5'(i));
      if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc) begin
        if (m_cnt[i] == 0) m_err = 1'b1;
        else m_cnt[i]--;
      end
    end
    if (s.mbusy) m_state = 2;
    else if (s.redir) begin
      m_fc    = FLUSH_CYCLES - 1;
      m_state = (FLUSH_CYCLES > 1) ? 1 : 0;
    end else if (m_state == 1) begin
      if (m_fc == 1) begin m_state = 0; m_fc = 0; end
      else m_fc--;
    end else m_state = 0;
  endtask

  // One clock cycle: drive, queue the expectation, compare at negedge,
  // advance the model at the following posedge.
  task automatic cyc(input stim_t s);
    exp_t e, p;
    drive(s);
    e = model_out(s);
    exp_q.push_back(e);
    @(negedge clk);
    p = exp_q.pop_front();
    o_issue  = issue;
    o_stall  = stall_if;
    o_bubble = bubble_ex;
    o_flush  = flush_if_id;
    o_busy   = sb_busy;
    o_err    = sb_err;
    chk("issue",       32'(issue),       32'(p.issue));
    chk("stall_if",    32'(stall_if),    32'(p.stall));
    chk("stall_id",    32'(stall_id),    32'(p.stall));
    chk("bubble_ex",   32'(bubble_ex),   32'(p.bubble));
    chk("flush_if_id", 32'(flush_if_id), 32'(p.flush));
    chk("sb_busy",     sb_busy,          p.busy);
    chk("sb_err",      32'(sb_err),      32'(p.err));
    @(posedge clk);
    model_step(s, e.issue);
    #1;
  endtask

  initial begin
    stim_t s;
    model_reset();

    // Reset: outputs low even with active inputs applied
    s = ins(1, 1, 3, 0, 0, 1, 4);
    s.mbusy = 1'b1;
    s.redir = 1'b1;
    drive(s);
    #12;
    chk("rst_issue",  32'(issue),       0);
    chk("rst_stall",  32'(stall_if),    0);
    chk("rst_bubble", 32'(bubble_ex),   0);
    chk("rst_flush",  32'(flush_if_id), 0);
    chk("rst_busy",   sb_busy,          0);
    chk("rst_err",    32'(sb_err),      0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // RAW on x5
    cyc(ins(1, 0, 0, 0, 0, 1, 5));
    chk("raw_wr_issue", 32'(o_issue), 1);
    cyc(ins(1, 1, 5, 0, 0, 0, 0));
    chk("raw_stall", 32'(o_stall), 1);
    chk("raw_bubble", 32'(o_bubble), 1);
    s = ins(1, 1, 5, 0, 0, 0, 0);
    s.wbw = 1'b1;
    s.wba = 5'd5;
    cyc(s);
    chk("raw_stall_wb_cycle", 32'(o_stall), 1);
    cyc(ins(1, 1, 5, 0, 0, 0, 0));
    chk("raw_release_issue", 32'(o_issue), 1);
    chk("raw_busy5", 32'(o_busy[5]), 0);

    // x0 exemption
    for (int i = 0; i < 4; i++) begin
      cyc(ins(1, 1, 0, 1, 0, 1, 0));
      chk("x0_issue", 32'(o_issue), 1);
      chk("x0_busy", o_busy, 0);
    end

    // WAW saturation on x7
    for (int i = 0; i < 3; i++) cyc(ins(1, 0, 0, 0, 0, 1, 7));
    cyc(ins(1, 0, 0, 0, 0, 1, 7));
    chk("waw_full_stall", 32'(o_stall), 1);
    chk("waw_full_issue", 32'(o_issue), 0);
    s = ins(1, 0, 0, 0, 0, 1, 7);
    s.wbw = 1'b1;
    s.wba = 5'd7;
    cyc(s);
    chk("waw_wb_cycle_stall", 32'(o_stall), 1);
    cyc(ins(1, 0, 0, 0, 0, 1, 7));
    chk("waw_after_wb_issue", 32'(o_issue), 1);
    s = ins(0, 0, 0, 0, 0, 0, 0);
    s.wbw = 1'b1;
    s.wba = 5'd7;
    for (int i = 0; i < 3; i++) cyc(s);
    cyc(ins(0, 0, 0, 0, 0, 0, 0));
    chk("waw_drained", 32'(o_busy[7]), 0);

    // Simultaneous inc/dec on x9
    cyc(ins(1, 0, 0, 0, 0, 1, 9));
    s = ins(1, 0, 0, 0, 0, 1, 9);
    s.wbw = 1'b1;
    s.wba = 5'd9;
    cyc(s);
    chk("incdec_issue", 32'(o_issue), 1);
    s = ins(0, 0, 0, 0, 0, 0, 0);
    s.wbw = 1'b1;
    s.wba = 5'd9;
    cyc(s);
    chk("incdec_busy9_still1", 32'(o_busy[9]), 1);
    cyc(ins(0, 0, 0, 0, 0, 0, 0));
    chk("incdec_busy9_clear", 32'(o_busy[9]), 0);
    chk("incdec_no_err", 32'(o_err), 0);

    // Redirect: two flush cycles then RUN
    s = ins(1, 0, 0, 0, 0, 0, 0);
    s.redir = 1'b1;
    cyc(s);
    chk("redir_flush1", 32'(o_flush), 1);
    chk("redir_issue1", 32'(o_issue), 0);
    cyc(ins(1, 0, 0, 0, 0, 0, 0));
    chk("redir_flush2", 32'(o_flush), 1);
    chk("redir_issue2", 32'(o_issue), 0);
    cyc(ins(1, 0, 0, 0, 0, 0, 0));
    chk("redir_done_flush", 32'(o_flush), 0);
    chk("redir_done_issue", 32'(o_issue), 1);

    // Release underflow on x20 sets the sticky error
    s = ins(0, 0, 0, 0, 0, 0, 0);
    s.wbw = 1'b1;
    s.wba = 5'd20;
    cyc(s);
    cyc(ins(0, 0, 0, 0, 0, 0, 0));
    chk("sb_err_set", 32'(o_err), 1);
    cyc(ins(0, 0, 0, 0, 0, 0, 0));
    chk("sb_err_sticky", 32'(o_err), 1);

    // mem_busy freeze with concurrent redirect and release of x3
    cyc(ins(1, 0, 0, 0, 0, 1, 3));
    cyc(ins(1, 0, 0, 0, 0, 1, 12));
    for (int i = 0; i < 3; i++) begin
      s = ins(1, 0, 0, 0, 0, 0, 0);
      s.mbusy = 1'b1;
      s.redir = 1'b1;
      if (i == 0) begin
        s.wbw = 1'b1;
        s.wba = 5'd3;
      end
      cyc(s);
      chk("mb_stall", 32'(o_stall), 1);
      chk("mb_flush", 32'(o_flush), 0);
      chk("mb_issue", 32'(o_issue), 0);
      chk("mb_bubble", 32'(o_bubble), 0);
      if (i == 1) chk("mb_busy3_released", 32'(o_busy[3]), 0);
    end
    s = ins(1, 0, 0, 0, 0, 0, 0);
    s.redir = 1'b1;
    cyc(s);
    chk("mb_flush_start", 32'(o_flush), 1);
    chk("mb_flush_issue", 32'(o_issue), 0);

    // Async reset in the middle of FLUSH
    drive(ins(1, 0, 0, 0, 0, 0, 0));
    #2;
    chk("pre_rst_flush", 32'(flush_if_id), 1);
    chk("pre_rst_busy12", 32'(sb_busy[12]), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flush",  32'(flush_if_id), 0);
    chk("mid_rst_bubble", 32'(bubble_ex),   0);
    chk("mid_rst_stall",  32'(stall_id),    0);
    chk("mid_rst_issue",  32'(issue),       0);
    chk("mid_rst_busy",   sb_busy,          0);
    chk("mid_rst_err",    32'(sb_err),      0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(ins(1, 1, 12, 0, 0, 0, 0));
    chk("post_rst_issue", 32'(o_issue), 1);
    chk("post_rst_flush", 32'(o_flush), 0);
    cyc(ins(0, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
